// File: rtl/step_ctrl_pkg.sv
// Shared types and default sizes for the step controller.
// Optional macro STEP_DEBOUNCE_EN is consumed by key_sync and step_ctrl.
package step_ctrl_pkg;

  typedef enum logic [1:0] {
    PAUSED  = 2'b00,
    RUNNING = 2'b01,
    STEP    = 2'b10
  } state_t;

  localparam int DIV_W_DEF = 32;
  localparam int SEL_W_DEF = 5;
  localparam int CNT_W_DEF = 8;

endpackage

// File: rtl/key_sync.sv
// Pushbutton conditioning: 2-FF synchronizer, optional debounce and falling-edge detect.
// Macro STEP_DEBOUNCE_EN enables the DB_CYCLES stability filter.
module key_sync
`ifdef STEP_DEBOUNCE_EN
  #(parameter int DB_CYCLES = 500000)
`endif
(
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic press
);

  logic sync1;
  logic sync2;
  logic filt;
  logic lvl_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
    end
  end

`ifdef STEP_DEBOUNCE_EN
  localparam int DB_W = $clog2(DB_CYCLES) + 1;
  logic [DB_W-1:0] db_cnt;

  // The filtered level only follows the synchronized level after it has
  // disagreed for DB_CYCLES consecutive cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      filt   <= 1'b1;
      db_cnt <= '0;
    end else if (sync2 == filt) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_W'(DB_CYCLES - 1)) begin
      filt   <= sync2;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + DB_W'(1);
    end
  end
`else
  assign filt = sync2;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      lvl_q <= 1'b1;
      press <= 1'b0;
    end else begin
      lvl_q <= filt;
      press <= lvl_q & ~filt;
    end
  end

endmodule

// File: rtl/step_ctrl.sv
// Tick sequencer: free-run at a selectable rate, pause, or single-step from a key.
// Macro STEP_DEBOUNCE_EN adds the DB_CYCLES key debounce filter.
module step_ctrl
  import step_ctrl_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF,
  parameter int SEL_W = SEL_W_DEF,
  parameter int CNT_W = CNT_W_DEF
`ifdef STEP_DEBOUNCE_EN
  , parameter int DB_CYCLES = 500000
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run_sw,
  input  logic             step_key_n,
  input  logic [SEL_W-1:0] rate_sel,
  output logic             tick,
  output logic [CNT_W-1:0] tick_count,
  output logic [1:0]       state_o,
  output logic             running
);

  state_t           state_q;
  state_t           state_d;
  logic             tick_d;
  logic             press;
  logic [DIV_W-1:0] rate_cnt;
  logic [DIV_W-1:0] rate_mask;
  logic [SEL_W:0]   shamt;

`ifdef STEP_DEBOUNCE_EN
  key_sync #(.DB_CYCLES(DB_CYCLES)) u_key_sync (
`else
  key_sync u_key_sync (
`endif
    .clk   (clk),
    .reset (reset),
    .key_n (step_key_n),
    .press (press)
  );

  // Shifts of DIV_W or more give an all-ones mask, i.e. the slowest rate.
  always_comb begin
    shamt     = {1'b0, rate_sel} + (SEL_W + 1)'(1);
    rate_mask = ~({DIV_W{1'b1}} << shamt);
  end

  always_comb begin
    state_d = state_q;
    tick_d  = 1'b0;
    case (state_q)
      PAUSED: begin
        if (run_sw)     state_d = RUNNING;
        else if (press) state_d = STEP;
      end
      STEP: begin
        state_d = run_sw ? RUNNING : PAUSED;
      end
      RUNNING: begin
        if (!run_sw) state_d = PAUSED;
        else         tick_d  = ((rate_cnt & rate_mask) == rate_mask);
      end
      default: state_d = PAUSED;
    endcase
    if (state_d == STEP) tick_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= PAUSED;
      tick       <= 1'b0;
      tick_count <= '0;
      rate_cnt   <= '0;
    end else begin
      state_q    <= state_d;
      tick       <= tick_d;
      tick_count <= tick_count + CNT_W'(tick);
      // Every entry into RUNNING restarts the period from zero.
      if (state_q != RUNNING && state_d == RUNNING) rate_cnt <= '0;
      else if (state_q == RUNNING)                  rate_cnt <= rate_cnt + DIV_W'(1);
    end
  end

  assign state_o = state_q;
  assign running = (state_q == RUNNING);

endmodule

// File: tb/tb_step_ctrl.sv
// Directed bench for step_ctrl: reset, free-run, single-step, run/press race, wrap, debounce.
module tb_step_ctrl;

`ifdef STEP_DEBOUNCE_EN
  localparam int DB_EXTRA = 8;
`else
  localparam int DB_EXTRA = 0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       run_sw;
  logic       step_key_n;
  logic [4:0] rate_sel;
  logic       tick;
  logic [7:0] tick_count;
  logic [1:0] state_o;
  logic       running;

  int checks = 0;
  int errors = 0;
  int tick_sum;

  always #5 clk = ~clk;

`ifdef STEP_DEBOUNCE_EN
  step_ctrl #(.DB_CYCLES(8)) dut (
`else
  step_ctrl dut (
`endif
    .clk        (clk),
    .reset      (reset),
    .run_sw     (run_sw),
    .step_key_n (step_key_n),
    .rate_sel   (rate_sel),
    .tick       (tick),
    .tick_count (tick_count),
    .state_o    (state_o),
    .running    (running)
  );

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset      = 1'b1;
    run_sw     = 1'b0;
    step_key_n = 1'b1;
    rate_sel   = 5'd1;
    step_clk();
    step_clk();
    reset = 1'b0;
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_count", 32'(tick_count), 32'd0);
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_running", 32'(running), 32'd0);

    // Idle for 20 cycles with key released.
    tick_sum = 0;
    for (int i = 0; i < 20; i++) begin
      step_clk();
      tick_sum += int'(tick);
    end
    check("idle_ticks", 32'(tick_sum), 32'd0);
    check("idle_count", 32'(tick_count), 32'd0);
    check("idle_state", 32'(state_o), 32'd0);

    // Free-run at period 4.
    run_sw = 1'b1;
    step_clk();
    check("run_entry_state", 32'(state_o), 32'd1);
    for (int i = 1; i <= 20; i++) begin
      step_clk();
      check($sformatf("run_tick_%0d", i), 32'(tick), 32'((i % 4) == 0));
    end
    step_clk();
    check("run_count5", 32'(tick_count), 32'd5);
    check("run_running", 32'(running), 32'd1);
    run_sw = 1'b0;
    step_clk();
    check("pause_state", 32'(state_o), 32'd0);
    check("pause_tick", 32'(tick), 32'd0);
    check("pause_running", 32'(running), 32'd0);
    check("pause_count", 32'(tick_count), 32'd5);

    // Single step: key low for 10 cycles.
    step_key_n = 1'b0;
    for (int i = 1; i <= 15 + DB_EXTRA; i++) begin
      step_clk();
      check($sformatf("step_tick_%0d", i), 32'(tick), 32'(i == 4 + DB_EXTRA));
      check($sformatf("step_state_%0d", i), 32'(state_o), (i == 4 + DB_EXTRA) ? 32'd2 : 32'd0);
      if (i == 10 + DB_EXTRA) step_key_n = 1'b1;
    end
    check("step_count", 32'(tick_count), 32'd6);

    // run_sw rises in the same cycle press fires: run wins, no step.
    step_key_n = 1'b0;
    for (int i = 1; i <= 8 + DB_EXTRA; i++) begin
      step_clk();
      check($sformatf("race_state_%0d", i), 32'(state_o), (i >= 4 + DB_EXTRA) ? 32'd1 : 32'd0);
      check($sformatf("race_tick_%0d", i), 32'(tick), 32'(i == 8 + DB_EXTRA));
      if (i == 3 + DB_EXTRA) begin
        run_sw     = 1'b1;
        step_key_n = 1'b1;
      end
    end
    run_sw = 1'b0;
    step_clk();
    check("race_exit_state", 32'(state_o), 32'd0);
    check("race_exit_tick", 32'(tick), 32'd0);
    check("race_count", 32'(tick_count), 32'd7);

    // 255 ticks at period 2, then wrap, then reset mid-run.
    reset = 1'b1;
    step_clk();
    reset = 1'b0;
    check("rst2_count", 32'(tick_count), 32'd0);
    rate_sel = 5'd0;
    run_sw   = 1'b1;
    step_clk();
    step_clk();
    step_clk();
    check("fast_first_tick", 32'(tick), 32'd1);
    for (int i = 3; i <= 511; i++) step_clk();
    check("fast_count255", 32'(tick_count), 32'd255);
    step_clk();
    check("fast_tick256", 32'(tick), 32'd1);
    step_clk();
    check("wrap_count", 32'(tick_count), 32'd0);
    check("wrap_tick", 32'(tick), 32'd0);
    reset = 1'b1;
    step_clk();
    check("midrst_tick", 32'(tick), 32'd0);
    check("midrst_state", 32'(state_o), 32'd0);
    check("midrst_running", 32'(running), 32'd0);
    check("midrst_count", 32'(tick_count), 32'd0);
    reset  = 1'b0;
    run_sw = 1'b0;

`ifdef STEP_DEBOUNCE_EN
    // Short glitch is filtered; a long press gives exactly one tick.
    step_key_n = 1'b0;
    for (int i = 0; i < 3; i++) step_clk();
    step_key_n = 1'b1;
    tick_sum = 0;
    for (int i = 0; i < 20; i++) begin
      step_clk();
      tick_sum += int'(tick);
    end
    check("db_glitch_ticks", 32'(tick_sum), 32'd0);
    step_key_n = 1'b0;
    tick_sum = 0;
    for (int i = 0; i < 20; i++) begin
      step_clk();
      tick_sum += int'(tick);
    end
    step_key_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step_clk();
      tick_sum += int'(tick);
    end
    check("db_press_ticks", 32'(tick_sum), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
